// File: rtl/led_flasher.sv
// Queued LED flasher: each event_pulse requests one active-low flash of ON_CYCLES,
// separated by GAP_CYCLES; up to MAX_PENDING requests wait behind the active one.
module led_flasher #(
    parameter int ON_CYCLES   = 4,
    parameter int GAP_CYCLES  = 2,
    parameter int MAX_PENDING = 3
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               event_pulse,
    input  logic                               clear,
    output logic                               led_n,
    output logic                               busy,
    output logic [$clog2(MAX_PENDING+1)-1:0]   pending,
    output logic                               overflow
);
    localparam int MAXC = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int PW   = $clog2(MAX_PENDING + 1);

    typedef enum logic [1:0] {IDLE, ON, GAP} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [PW-1:0]   pend_q;
    logic            led_q;
    logic            ovf_q;
    logic            last_gap;
    logic            take;

    // A new flash may start from IDLE or seamlessly from the final GAP cycle.
    always_comb begin
        last_gap = (state_q == GAP) && (cnt_q == CW'(GAP_CYCLES - 1));
        take     = ((state_q == IDLE) || last_gap) && ((pend_q != '0) || event_pulse);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
            led_q   <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            ovf_q <= 1'b0;
            if (clear) begin
                state_q <= IDLE;
                cnt_q   <= '0;
                pend_q  <= '0;
                led_q   <= 1'b1;
            end else if (take) begin
                state_q <= ON;
                cnt_q   <= '0;
                led_q   <= 1'b0;
                // A coincident pulse replaces the queued request just consumed.
                if ((pend_q != '0) && !event_pulse)
                    pend_q <= pend_q - PW'(1);
            end else begin
                if (event_pulse) begin
                    if (pend_q == PW'(MAX_PENDING))
                        ovf_q <= 1'b1;
                    else
                        pend_q <= pend_q + PW'(1);
                end
                case (state_q)
                    ON: begin
                        if (cnt_q == CW'(ON_CYCLES - 1)) begin
                            state_q <= GAP;
                            cnt_q   <= '0;
                            led_q   <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    GAP: begin
                        if (last_gap) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign led_n    = led_q;
    assign busy     = (state_q != IDLE);
    assign pending  = pend_q;
    assign overflow = ovf_q;
endmodule

// File: tb/tb_led_flasher.sv
// Scoreboard bench for led_flasher: a countdown model of each flash predicts outputs
// per cycle; directed scenarios cover latency, queueing, overflow, clear and reset.
module tb_led_flasher;
    localparam int ON   = 4;
    localparam int GAP  = 2;
    localparam int MAXP = 3;

    logic       clk;
    logic       reset_n;
    logic       event_pulse;
    logic       clear;
    logic       led_n;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    led_flasher #(.ON_CYCLES(ON), .GAP_CYCLES(GAP), .MAX_PENDING(MAXP)) dut (
        .clk(clk), .reset_n(reset_n), .event_pulse(event_pulse), .clear(clear),
        .led_n(led_n), .busy(busy), .pending(pending), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       led;
        logic       bsy;
        logic [1:0] pnd;
        logic       ovf;
    } exp_t;

    exp_t sb[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // Model: m_rem counts remaining cycles of the current flash+gap (0 = idle).
    int   m_rem  = 0;
    int   m_pend = 0;
    bit   m_ovf  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic model_step(input bit ev, input bit clr);
        bit tk;
        m_ovf = 0;
        if (clr) begin
            m_rem  = 0;
            m_pend = 0;
        end else begin
            tk = (m_rem <= 1) && ((m_pend > 0) || ev);
            if (tk) begin
                m_rem = ON + GAP;
                if (m_pend > 0 && !ev) m_pend--;
            end else begin
                if (m_rem > 0) m_rem--;
                if (ev) begin
                    if (m_pend == MAXP) m_ovf = 1;
                    else m_pend++;
                end
            end
        end
    endtask

    task automatic cyc(input bit ev, input bit clr);
        exp_t e;
        exp_t g;
        @(negedge clk);
        event_pulse = ev;
        clear       = clr;
        model_step(ev, clr);
        e.led = !(m_rem > GAP);
        e.bsy = (m_rem > 0);
        e.pnd = 2'(m_pend);
        e.ovf = m_ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        event_pulse = 1'b0;
        clear       = 1'b0;
        if (sb.size() == 0) begin
            check("sb_underflow", 0, 1);
        end else begin
            g = sb.pop_front();
            check("led_n",    led_n,    g.led);
            check("busy",     busy,     g.bsy);
            check("pending",  pending,  g.pnd);
            check("overflow", overflow, g.ovf);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0);
    endtask

    initial begin
        logic [6:0] lp;
        logic [6:0] bp;
        int         flashes;
        logic       prev_led;

        reset_n     = 1'b0;
        event_pulse = 1'b0;
        clear       = 1'b0;
        #12;
        check("rst_led_n",    led_n,    1);
        check("rst_busy",     busy,     0);
        check("rst_pending",  pending,  0);
        check("rst_overflow", overflow, 0);
        @(negedge clk);
        reset_n = 1'b1;
        idle(3);

        // Single pulse: 1-cycle latency, 4 lit, 2 gap, then idle.
        lp = 7'b1110000;
        bp = 7'b0111111;
        cyc(1, 0);
        check("single_lat_led", led_n, 0);
        for (int k = 1; k < 7; k++) begin
            cyc(0, 0);
            check("single_led",  led_n, lp[k]);
            check("single_busy", busy,  bp[k]);
        end
        idle(3);

        // Two pulses two cycles apart: back-to-back flashes without IDLE.
        cyc(1, 0); cyc(0, 0); cyc(1, 0);
        check("two_pending", pending, 1);
        for (int k = 0; k < 12; k++) begin
            cyc(0, 0);
            if (k < 8) check("two_no_idle", busy, 1);
        end
        idle(3);

        // Five consecutive pulses: queue fills, fifth dropped, four flashes.
        flashes  = 0;
        prev_led = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cyc(1, 0);
            if (prev_led && !led_n) flashes++;
            prev_led = led_n;
        end
        check("five_ovf_pulse", overflow, 1);
        for (int k = 0; k < 30; k++) begin
            cyc(0, 0);
            if (k == 0) check("five_ovf_once", overflow, 0);
            if (prev_led && !led_n) flashes++;
            prev_led = led_n;
        end
        check("five_flashes", flashes, 4);

        // Full queue + pulse on last GAP cycle: take, pending holds, no overflow.
        for (int k = 0; k < 4; k++) cyc(1, 0);
        check("full_pending", pending, 3);
        cyc(0, 0); cyc(0, 0);
        cyc(1, 0);
        check("gap_take_led", led_n,    0);
        check("gap_take_pnd", pending,  3);
        check("gap_take_ovf", overflow, 0);
        idle(30);

        // Clear during ON with pending=2 and a coincident pulse.
        cyc(1, 0); cyc(1, 0); cyc(1, 0);
        check("clr_pre_pnd", pending, 2);
        cyc(1, 1);
        check("clr_led",  led_n,    1);
        check("clr_pnd",  pending,  0);
        check("clr_busy", busy,     0);
        check("clr_ovf",  overflow, 0);
        idle(4);

        // Random traffic with occasional clear.
        for (int k = 0; k < 300; k++)
            cyc(($urandom_range(0, 9) < 3), ($urandom_range(0, 49) == 0));
        idle(10);

        // Asynchronous reset mid-ON with queued requests.
        cyc(1, 0); cyc(1, 0); cyc(0, 0);
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_led_n",   led_n,   1);
        check("arst_pending", pending, 0);
        check("arst_busy",    busy,    0);
        m_rem  = 0;
        m_pend = 0;
        m_ovf  = 0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            cyc(0, 0);
            check("post_rst_dark", led_n, 1);
        end
        cyc(1, 0);
        check("post_rst_flash", led_n, 0);
        idle(8);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/led_flasher.md
LED_FLASHER -- requirements
Module: led_flasher

Interface
REQ-001 The block SHALL have parameter ON_CYCLES, default 4, meaning the number of clock cycles led_n is held low per flash (legal range >=1).
REQ-002 The block SHALL have parameter GAP_CYCLES, default 2, meaning the number of clock cycles led_n is held high between consecutive flashes (legal range >=1).
REQ-003 The block SHALL have parameter MAX_PENDING, default 3, meaning the number of queued flash requests retained (legal range >=1).
REQ-004 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit, the asynchronous active-low reset.
REQ-006 The block SHALL have port event_pulse, input, 1 bit, a single-cycle flash request, typically a debounced key pulse.
REQ-007 The block SHALL have port clear, input, 1 bit, a synchronous abort of the current flash and all queued requests.
REQ-008 The block SHALL have port led_n, output, 1 bit, the active-low LED drive (0 = lit), registered.
REQ-009 The block SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-010 The block SHALL have port pending, output, $clog2(MAX_PENDING+1) bits, the count of queued requests not yet started.
REQ-011 The block SHALL have port overflow, output, 1 bit, a registered one-cycle pulse indicating a dropped request.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, ON and GAP, plus one phase counter wide enough for max(ON_CYCLES, GAP_CYCLES).
REQ-013 A "take" SHALL occur at an edge when the state is IDLE, or GAP on its last cycle, and (pending>0 or event_pulse=1).
REQ-014 On a take, the next state SHALL be ON, the phase counter SHALL load 0, and led_n SHALL be 0 from that edge onward.
REQ-015 On a take with pending>0, pending SHALL become pending-1+event_pulse; with pending=0, the event_pulse itself SHALL be consumed and pending SHALL remain 0.
REQ-016 Latency SHALL be exactly 1 clock: event_pulse sampled high at edge k in IDLE with pending=0 gives led_n=0 after edge k.
REQ-017 In ON, led_n SHALL stay 0 for exactly ON_CYCLES cycles, then the state SHALL go to GAP with led_n=1.
REQ-018 In GAP, led_n SHALL stay 1 for exactly GAP_CYCLES cycles; at the last GAP cycle the state SHALL go to ON on a take, else to IDLE.
REQ-019 An event_pulse without a take SHALL increment pending if pending<MAX_PENDING.
REQ-020 An event_pulse without a take and with pending=MAX_PENDING SHALL be dropped, with overflow=1 for the following cycle only.
REQ-021 An event_pulse coinciding with a take at pending=MAX_PENDING SHALL leave pending at MAX_PENDING and SHALL NOT raise overflow.
REQ-022 event_pulse held high for N consecutive cycles SHALL be treated as N requests.
REQ-023 clear=1 SHALL force, at the next edge, state IDLE, led_n=1, pending=0 and the phase counter to 0, and any event_pulse in the same cycle SHALL be discarded without overflow.
REQ-024 The pending count SHALL never wrap, neither below 0 nor above MAX_PENDING.

Reset
REQ-025 While reset_n=0, asynchronously: state=IDLE, led_n=1, busy=0, pending=0, overflow=0, phase counter=0.
REQ-026 Reset deassertion mid-flash SHALL resume from IDLE with no residual flash or queued request.

Verification
REQ-027 Defaults, single event_pulse at cycle 10 -> led_n=0 cycles 11-14, 1 from cycle 15; busy high cycles 11-16; IDLE at cycle 17.
REQ-028 Two event_pulses at cycles 10 and 12 -> pending=1 after cycle 12; second flash led_n=0 cycles 17-20 with no IDLE in between.
REQ-029 Five event_pulses on consecutive cycles 10-14 -> first consumed, pending reaches 3, fifth dropped, overflow=1 in cycle 15 only; four flashes total.
REQ-030 pending=3 and event_pulse on the last GAP cycle -> take occurs, pending stays 3, overflow stays 0.
REQ-031 clear asserted during ON with pending=2, event_pulse in the same cycle -> next cycle led_n=1, pending=0, busy=0, overflow=0.
REQ-032 reset_n pulled low mid-ON, asynchronous to clk -> led_n=1 and pending=0 immediately; after release, no flash occurs until a new event_pulse.
